numb_text_seq: RTL and testbench
================================

// Module: numb_text_seq
// PURPOSE
//  Sequencer that renders a binary number as decimal text on the VGA overlay.
//  Converts value to BCD serially (shift-add-3), then feeds digits MSB-first to a
//  shared numb2char instance (1-cycle registered latency) and writes the returned
//  char codes into the character buffer at consecutive addresses.
//  Sits between game/score logic and the char buffer feeding the text renderer.
// PARAMETERS
//  VAL_W   14  width of binary input value
//  DIGITS  4   number of decimal digits emitted (buffer cells written)
//  ADDR_W  7   character buffer address width
// PORTS
//  clk        in   1       system clock
//  rst        in   1       synchronous reset, active-high
//  start      in   1       request conversion; sampled only in IDLE
//  value      in   VAL_W   binary number, latched on accepted start
//  base_addr  in   ADDR_W  buffer address of leftmost digit, latched on start
//  busy       out  1       high from cycle after accepted start until DONE
//  done       out  1       one-cycle pulse after last buffer write
//  digit_out  out  4       digit to numb2char input_numb; 4'hF when not emitting
//  char_in    in   7       char_code from numb2char (valid 1 cycle after digit_out)
//  wr_en      out  1       char buffer write strobe
//  wr_addr    out  ADDR_W  char buffer write address
//  wr_data    out  7       char buffer write data (registered copy of char_in path)
// BEHAVIOUR
//  - Reset: state=IDLE, busy=0, done=0, wr_en=0, wr_addr=0, wr_data=0, digit_out=4'hF.
//  - FSM: IDLE -> CONV -> EMIT -> FLUSH -> DONE -> IDLE.
//  - IDLE: start=1 latches value/base_addr, clears BCD reg, bit cnt=0 -> CONV.
//  - CONV: VAL_W cycles; each cycle add 3 to every BCD nibble >=5, then shift left
//    by one bit, inserting value MSB. BCD reg width 4*DIGITS, extra carry bits kept
//    internally to detect overflow.
//  - Overflow: value > 10^DIGITS-1 -> all digits forced to 9 (saturate).
//  - EMIT: DIGITS cycles, digit i (i=0 most significant) on digit_out in cycle i.
//  - Write pipeline: wr_en=1, wr_addr=base_addr+i, wr_data=char_in one cycle after
//    digit i is presented; FLUSH covers the final write. wr_addr wraps mod 2^ADDR_W.
//  - DONE: done=1, busy=0 for one cycle, -> IDLE.
//  - Latency (start sampled at cycle 0): CONV cycles 1..VAL_W, writes at cycles
//    VAL_W+2..VAL_W+DIGITS+1, done at VAL_W+DIGITS+2.
//  - start while not IDLE (incl. DONE cycle): ignored, no queuing.
//  - value/base_addr changes after acceptance: no effect on current operation.
//  - rst mid-operation: next cycle all outputs at reset values; no further writes;
//    already-written cells left unchanged; no done pulse.
//  - Exactly DIGITS writes per accepted start, never more.
// CONFIGURATION
//  NUMB_SEQ_BLANK_EN defined: leading zero digits emitted as 4'hF (numb2char maps
//    to SPACE); least significant digit never blanked (value 0 -> "   0").
//    Blanking ends at first nonzero digit. Write count/timing unchanged.
//  Not defined: all digits emitted as-is, leading zeros included ("0042").
// TESTING  (VAL_W=14, DIGITS=4, behavioural numb2char model with 1-cycle register)
//  1. value=1234, base=10, start@0 -> writes C_1,C_2,C_3,C_4 to 10..13 at cycles
//     16..19; done@20; busy high cycles 1..19.
//  2. value=42 -> without macro "0042"; with NUMB_SEQ_BLANK_EN SPACE,SPACE,C_4,C_2;
//     value=0 with macro -> SPACE,SPACE,SPACE,C_0.
//  3. value=16383 -> C_9 x4 (saturation); value=9999 -> C_9 x4, no overflow flag path.
//  4. base=126 (ADDR_W=7), value=5678 -> writes to 126,127,0,1.
//  5. start pulsed at cycles 5 and 20 (DONE) of a running op -> ignored; exactly
//     4 writes; start@21 accepted.
//  6. rst at cycle 18 (after 2 writes) -> wr_en=0, busy=0 from 19, no done;
//     fresh start after reset completes normally.

Source files
------------

// File: rtl/numb_text_seq.sv
// Binary-to-decimal text sequencer: serial double-dabble conversion, then MSB-first
// digit emission through an external numb2char and char-buffer writes. Macro: NUMB_SEQ_BLANK_EN.
module numb_text_seq #(
    parameter int VAL_W  = 14,
    parameter int DIGITS = 4,
    parameter int ADDR_W = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [VAL_W-1:0]  value,
    input  logic [ADDR_W-1:0] base_addr,
    output logic              busy,
    output logic              done,
    output logic [3:0]        digit_out,
    input  logic [6:0]        char_in,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [6:0]        wr_data
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(VAL_W + 1);
    localparam int IDX_W = $clog2(DIGITS + 1);

    typedef enum logic [2:0] {
        IDLE,
        CONV,
        EMIT,
        FLUSH,
        DONE
    } state_t;

    state_t            state, state_next;
    logic [VAL_W-1:0]  val_sr;
    logic [BCD_W-1:0]  bcd, bcd_adj;
    logic              ovf;
    logic [CNT_W-1:0]  cnt;
    logic [IDX_W-1:0]  idx;
    logic [ADDR_W-1:0] base;
    logic [3:0]        cur_digit;
`ifdef NUMB_SEQ_BLANK_EN
    logic              lead;
`endif

    // Add-3 correction on every nibble before the shift
    always_comb begin
        bcd_adj = bcd;
        for (int unsigned n = 0; n < DIGITS; n++) begin
            if (bcd[4*n +: 4] >= 4'd5)
                bcd_adj[4*n +: 4] = bcd[4*n +: 4] + 4'd3;
        end
    end

    always_comb begin
        cur_digit = 4'd0;
        for (int unsigned n = 0; n < DIGITS; n++) begin
            if (idx == IDX_W'(n))
                cur_digit = bcd[4*(DIGITS-1-n) +: 4];
        end
        if (ovf)
            cur_digit = 4'd9;
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        digit_out  = 4'hF;
        unique case (state)
            IDLE: begin
                if (start)
                    state_next = CONV;
            end
            CONV: begin
                busy = 1'b1;
                if (cnt == CNT_W'(VAL_W - 1))
                    state_next = EMIT;
            end
            EMIT: begin
                busy = 1'b1;
`ifdef NUMB_SEQ_BLANK_EN
                if (lead && cur_digit == 4'd0 && idx != IDX_W'(DIGITS - 1))
                    digit_out = 4'hF;
                else
                    digit_out = cur_digit;
`else
                digit_out = cur_digit;
`endif
                if (idx == IDX_W'(DIGITS - 1))
                    state_next = FLUSH;
            end
            FLUSH: begin
                busy       = 1'b1;
                state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            val_sr  <= '0;
            bcd     <= '0;
            ovf     <= 1'b0;
            cnt     <= '0;
            idx     <= '0;
            base    <= '0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
`ifdef NUMB_SEQ_BLANK_EN
            lead    <= 1'b1;
`endif
        end else begin
            state <= state_next;
            wr_en <= (state == EMIT);
            unique case (state)
                IDLE: begin
                    if (start) begin
                        val_sr <= value;
                        base   <= base_addr;
                        bcd    <= '0;
                        ovf    <= 1'b0;
                        cnt    <= '0;
                    end
                end
                CONV: begin
                    // A bit shifted out of the top nibble means the value exceeds DIGITS digits
                    bcd    <= {bcd_adj[BCD_W-2:0], val_sr[VAL_W-1]};
                    ovf    <= ovf | bcd_adj[BCD_W-1];
                    val_sr <= val_sr << 1;
                    cnt    <= cnt + 1'b1;
                    idx    <= '0;
`ifdef NUMB_SEQ_BLANK_EN
                    lead   <= 1'b1;
`endif
                end
                EMIT: begin
                    wr_addr <= base + ADDR_W'(idx);
                    idx     <= idx + 1'b1;
`ifdef NUMB_SEQ_BLANK_EN
                    lead    <= lead & (cur_digit == 4'd0);
`endif
                end
                default: ;
            endcase
        end
    end

    // numb2char already registers its output, so the write data aligns with wr_en directly
    always_comb begin
        wr_data = '0;
        if (wr_en)
            wr_data = char_in;
    end

endmodule

// File: tb/tb_numb_text_seq.sv
// Randomized self-checking bench for numb_text_seq with a behavioural numb2char model.
module tb_numb_text_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [13:0] value;
    logic [6:0]  base_addr;
    logic        busy, done, wr_en;
    logic [3:0]  digit_out;
    logic [6:0]  char_in;
    logic [6:0]  wr_addr, wr_data;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    numb_text_seq #(.VAL_W(14), .DIGITS(4), .ADDR_W(7)) dut (
        .clk(clk), .rst(rst), .start(start), .value(value), .base_addr(base_addr),
        .busy(busy), .done(done), .digit_out(digit_out), .char_in(char_in),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    function automatic logic [6:0] char_code(input logic [3:0] d);
        return (d == 4'hF) ? 7'd32 : 7'd48 + {3'd0, d};
    endfunction

    // numb2char stand-in: one registered cycle of latency
    always @(posedge clk) char_in <= char_code(digit_out);

    task automatic check(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference digits: saturate at 9999, then decimal digits MSB first
    task automatic ref_digits(input int v, output logic [3:0] d [4]);
        int sat;
        int p;
        bit lead;
        sat = (v > 9999) ? 9999 : v;
        p = 1000;
        lead = 1'b1;
        for (int i = 0; i < 4; i++) begin
            d[i] = 4'((sat / p) % 10);
            p = p / 10;
`ifdef NUMB_SEQ_BLANK_EN
            if (lead && d[i] == 4'd0 && i != 3)
                d[i] = 4'hF;
            else
                lead = 1'b0;
`endif
        end
    endtask

    // Cycle k is the interval after the (k-1)th edge following the start-sampling edge
    task automatic run_op(input int v, input int b, input int rst_cyc, input int st_a, input int st_b);
        logic [3:0] d [4];
        bit in_rst;
        ref_digits(v, d);
        value = 14'(v);
        base_addr = 7'(b);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        value = 14'($urandom);
        base_addr = 7'($urandom);
        for (int k = 1; k <= 20; k++) begin
            in_rst = (rst_cyc > 0) && (k > rst_cyc);
            if (in_rst) begin
                check("busy_rst", busy, 0);
                check("done_rst", done, 0);
                check("wr_en_rst", wr_en, 0);
                check("wr_addr_rst", wr_addr, 0);
                check("wr_data_rst", wr_data, 0);
                check("digit_rst", digit_out, 15);
            end else begin
                check("busy", busy, (k <= 19) ? 1 : 0);
                check("done", done, (k == 20) ? 1 : 0);
                check("wr_en", wr_en, (k >= 16 && k <= 19) ? 1 : 0);
                check("digit", digit_out, (k >= 15 && k <= 18) ? int'(d[k-15]) : 15);
                if (k >= 16 && k <= 19) begin
                    check("wr_addr", wr_addr, (b + k - 16) % 128);
                    check("wr_data", wr_data, int'(char_code(d[k-16])));
                end
            end
            rst = (k == rst_cyc);
            start = (rst_cyc == 0 || k < rst_cyc) && (k == st_a || k == st_b);
            @(posedge clk); #1;
        end
        rst = 1'b0;
        start = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        value = '0;
        base_addr = '0;
        repeat (3) @(posedge clk);
        #1;
        check("busy_reset", busy, 0);
        check("done_reset", done, 0);
        check("wr_en_reset", wr_en, 0);
        check("wr_addr_reset", wr_addr, 0);
        check("wr_data_reset", wr_data, 0);
        check("digit_reset", digit_out, 15);
        rst = 1'b0;
        @(posedge clk); #1;

        run_op(1234, 10, 0, 0, 0);
        run_op(42, 3, 0, 0, 0);
        run_op(0, 50, 0, 0, 0);
        run_op(402, 60, 0, 0, 0);
        run_op(16383, 20, 0, 0, 0);
        run_op(9999, 30, 0, 0, 0);
        run_op(10000, 31, 0, 0, 0);
        run_op(5678, 126, 0, 0, 0);
        run_op(7, 90, 0, 5, 20);
        run_op(3141, 100, 0, 0, 0);
        run_op(2718, 40, 18, 0, 0);
        run_op(8765, 70, 0, 0, 0);

        for (int t = 0; t < 40; t++) begin
            int v, sel, rc;
            sel = $urandom_range(0, 3);
            case (sel)
                0:       v = $urandom_range(0, 99);
                1:       v = $urandom_range(0, 9999);
                2:       v = $urandom_range(9990, 16383);
                default: v = $urandom_range(0, 16383);
            endcase
            rc = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 19) : 0;
            run_op(v, $urandom_range(0, 127), rc, $urandom_range(1, 20), $urandom_range(0, 20));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
